// File: rtl/calc_input_sequencer.sv
// calc_input_sequencer: Enter-key conditioning and operand/command sequencer
// for the project 5 calculator function unit.
//
// Build option: define CALC_DEBOUNCE_EN to enable the debounce counter
// (sized by DB_CYCLES). Without it the synchronized key is used directly,
// which is only meant for fast simulation.
module calc_input_sequencer #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned MUL_STEPS = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       enter_n,
    input  logic [7:0] SW,
    output logic [3:0] opcode,
    output logic [7:0] opA,
    output logic [7:0] opB,
    output logic       start,
    output logic       step,
    output logic [3:0] step_cnt,
    output logic       err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        LOAD_OP  = 3'd0,
        LOAD_A   = 3'd1,
        LOAD_B   = 3'd2,
        MUL_STEP = 3'd3
    } state_e;

    localparam logic [3:0] OPC_MAX   = 4'd12;
    localparam logic [3:0] OPC_NOT   = 4'd4;
    localparam logic [3:0] OPC_NEG   = 4'd7;
    localparam logic [3:0] OPC_MUL   = 4'd12;
    localparam logic [3:0] STEP_LAST = 4'(MUL_STEPS);

    if (DB_CYCLES < 1 || DB_CYCLES > 1048575) begin : g_bad_db_cycles
        $error("calc_input_sequencer: DB_CYCLES out of range 1..2^20-1");
    end
    if (MUL_STEPS < 1 || MUL_STEPS > 15) begin : g_bad_mul_steps
        $error("calc_input_sequencer: MUL_STEPS out of range 1..15");
    end

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic       sync1_q, sync2_q;
    logic [1:0] vld_q;
    logic       armed_q;
    logic       db_level;
    logic       db_prev_q;
    logic       press;

    // Two-flop synchronizer for the asynchronous Enter key
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= enter_n;
            sync2_q <= sync1_q;
        end
    end

    // Presses are only accepted once a real released level has been seen
    // after reset, so a key held through reset release cannot fire.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            vld_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            vld_q <= {vld_q[0], 1'b1};
            if (vld_q[1] && sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam logic [19:0] DB_LIM = 20'(DB_CYCLES);

    logic [19:0] db_cnt_q, db_cnt_d;
    logic        db_level_q, db_level_d;

    // Count while the synchronized key disagrees with the accepted level;
    // accept the new level on the edge where the count reaches DB_CYCLES
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q + 20'd1 == DB_LIM) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 20'd1;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b1;
        end else begin
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
        end
    end

    assign db_level = db_level_q;
`else
    assign db_level = sync2_q;
`endif

    // Previous debounced level, for falling-edge detection
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            db_prev_q <= 1'b1;
        end else begin
            db_prev_q <= db_level;
        end
    end

    assign press = armed_q & db_prev_q & ~db_level;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_e     state_q;
    logic [3:0] opcode_q;
    logic [7:0] opa_q, opb_q;
    logic       start_q, step_q, err_q;
    logic [3:0] step_cnt_q;
    logic [3:0] step_cnt_inc;

    assign step_cnt_inc = step_cnt_q + 4'd1;

    // Capture switches into the register for the current phase and issue strobes
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LOAD_OP;
            opcode_q   <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            start_q    <= 1'b0;
            step_q     <= 1'b0;
            step_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            start_q <= 1'b0;
            step_q  <= 1'b0;
            if (press) begin
                case (state_q)
                    LOAD_OP: begin
                        if (SW[3:0] <= OPC_MAX) begin
                            opcode_q   <= SW[3:0];
                            err_q      <= 1'b0;
                            step_cnt_q <= '0;
                            state_q    <= LOAD_A;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    LOAD_A: begin
                        opa_q <= SW;
                        if (opcode_q == OPC_NOT || opcode_q == OPC_NEG) begin
                            opb_q   <= '0;
                            start_q <= 1'b1;
                            state_q <= LOAD_OP;
                        end else begin
                            state_q <= LOAD_B;
                        end
                    end
                    LOAD_B: begin
                        opb_q   <= SW;
                        start_q <= 1'b1;
                        if (opcode_q == OPC_MUL) begin
                            step_cnt_q <= '0;
                            state_q    <= MUL_STEP;
                        end else begin
                            state_q <= LOAD_OP;
                        end
                    end
                    MUL_STEP: begin
                        step_q     <= 1'b1;
                        step_cnt_q <= step_cnt_inc;
                        if (step_cnt_inc == STEP_LAST) begin
                            state_q <= LOAD_OP;
                        end
                    end
                    default: begin
                        state_q <= LOAD_OP;
                    end
                endcase
            end
        end
    end

    assign opcode   = opcode_q;
    assign opA      = opa_q;
    assign opB      = opb_q;
    assign start    = start_q;
    assign step     = step_q;
    assign step_cnt = step_cnt_q;
    assign err      = err_q;
    assign state    = state_q;

endmodule

// File: doc/calc_input_sequencer.md
# calc_input_sequencer

Upstream front end of the project 5 calculator: conditions the raw active-low Enter key and sequences the operator's Enter presses into opcode, operand A, operand B and multiply-step commands for the function unit. It synchronizes and debounces KEY[1], converts each press into a single-cycle event, and captures SW[7:0] into the correct register for the current input phase. It presents a one-cycle `start` strobe with stable operands when an operation is complete, then `step` strobes for the shift-add multiply.

## Interface
- `DB_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Benches override it to 1. Legal range is 1..2^20-1.
- `MUL_STEPS`, default 8: number of step presses accepted after a multiply start.

Ports:
- `CLOCK_50`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset, driven from KEY[0].
- `enter_n`  in  1  raw Enter key (KEY[1]), active low, asynchronous.
- `SW`  in  8  data switches.
- `opcode`  out  4  captured opcode.
- `opA`  out  8  captured operand A.
- `opB`  out  8  captured operand B.
- `start`  out  1  one-cycle strobe meaning the operation is ready.
- `step`  out  1  one-cycle multiply-step strobe.
- `step_cnt`  out  4  number of multiply steps issued (0..MUL_STEPS).
- `err`  out  1  invalid opcode entered.
- `state`  out  3  FSM state, for debug and LEDs.

## Operation
- Input conditioning: `enter_n` passes through a 2-FF synchronizer, then the debouncer, producing `db_level`. A press is `db_level` falling; it produces a 1-cycle `press` event.
- FSM states:
  - LOAD_OP = 0
  - LOAD_A = 1
  - LOAD_B = 2
  - MUL_STEP = 3
- LOAD_OP + press:
  - If SW[3:0] ≤ 12: `opcode` ← SW[3:0], `err` ← 0, go to LOAD_A.
  - If SW[3:0] is 13..15: `err` ← 1; registers and state are unchanged.
  - SW[7:4] is ignored.
- LOAD_A + press: `opA` ← SW.
  - Unary opcodes (4 = ones' complement, 7 = negate): `opB` ← 0, `start` ← 1, go to LOAD_OP.
  - All other opcodes: go to LOAD_B.
- LOAD_B + press: `opB` ← SW, `start` ← 1.
  - Opcode 12 (multiply): `step_cnt` ← 0, go to MUL_STEP.
  - Otherwise: go to LOAD_OP.
- MUL_STEP + press: `step` ← 1, `step_cnt` ← `step_cnt` + 1. When the new count equals MUL_STEPS, go to LOAD_OP. SW is ignored in this state.
- Holding registers: `opcode`, `opA` and `opB` hold their values until the next capture.
- Re-entering LOAD_A: `step_cnt` is cleared to 0.
- Holding Enter: a held key generates exactly one press. Release generates none.

## Timing
- Reset values (asynchronous): `state`=LOAD_OP, `opcode`=0, `opA`=0, `opB`=0, `start`=0, `step`=0, `step_cnt`=0, `err`=0. Both synchronizer flops and `db_level` reset to 1; the debounce counter resets to 0.
- Debounce: the counter increments while sync2 ≠ `db_level` and clears when they are equal. `db_level` toggles on the edge where the count reaches DB_CYCLES. A glitch shorter than DB_CYCLES cycles therefore produces no press.
- Latency:
  - `enter_n` low at edge 0 → sync2 low after edge 1.
  - `db_level` low after edge 1+DB_CYCLES.
  - `press` is high for the following cycle.
  - The capture, `start` and `step` are registered at edge 2+DB_CYCLES.
- `start` and `step` are registered and high for exactly one cycle. They rise on the same edge as the captured value, so operands are valid whenever `start` is high.
- `start` and `step` never assert in the same cycle.
- Reset mid-operation: reset asserted in any state (including mid-debounce or MUL_STEP) aborts immediately to reset values. A key held through reset release produces no press until it is released and pressed again.

## Configuration
- `CALC_DEBOUNCE_EN` defined: debounce counter as described, sized by DB_CYCLES.
- Undefined: `db_level` = sync2 (no counter; DB_CYCLES is ignored), so the capture occurs at edge 2. Every sampled edge counts as a press; this mode is for fast simulation only.

## Test plan
- Reset, then opcode 0x01, A=0x94, B=0xA6: `start` pulses once after the third press with `opcode`=1, `opA`=0x94, `opB`=0xA6; `state` returns to 0.
- Opcode 0x04, A=0x05: `start` pulses after the second press with `opB`=0x00; a further press is taken as a new opcode.
- Opcode 0x0C, A=0x66, B=0x2D, then 8 presses:
  - `start` pulses once, then `step` pulses 8 times with `step_cnt` 1..8.
  - After the 8th step `state` = LOAD_OP.
  - A 9th press latches an opcode.
- SW=0x0E pressed in LOAD_OP: `err`=1, `state` stays 0. Then SW=0x02 pressed: `err`=0, `state`=1.
- With DB_CYCLES=4 and `CALC_DEBOUNCE_EN`: a 3-cycle low glitch gives no press; a 5-cycle low gives exactly one press at edge 6 after the first low sample.
- `reset_n` pulsed low after the 3rd multiply step: all outputs are at reset values before the next edge; the next press latches an opcode.
